// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and constants for the spi command sequencer: command record,
// sequencer state encoding and spi memory geometry.
package spi_cmd_sequencer_pkg;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } spi_cmd_t;

  typedef enum logic {PARK, BUSY} spi_seq_state_t;

  localparam int         SPI_MEM_DEPTH = 32;
  localparam logic [7:0] PARK_ADDR_DEF = 8'hFF;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Host request/response channel plus the spi command/result wires.
// slave is the sequencer's view; master is the host + spi side.
interface spi_cmd_sequencer_if;
  import spi_cmd_sequencer_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       spi_wr;
  logic [7:0] spi_addr;
  logic [7:0] spi_din;
  logic [7:0] spi_dout;
  logic       spi_err;
  logic       spi_done;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, spi_dout, spi_err, spi_done,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, spi_wr, spi_addr, spi_din
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, spi_dout, spi_err, spi_done,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, spi_wr, spi_addr, spi_din
  );

endinterface

// File: rtl/spi_cmd_sequencer_fifo.sv
// Request FIFO of spi commands with a combinational head; a push is accepted
// while full when a pop happens on the same edge.
module spi_cmd_sequencer_fifo
  import spi_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  spi_cmd_t push_data_i,
  input  logic     pop_i,
  output spi_cmd_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(DEPTH);

  spi_cmd_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Command front-end for the free-running spi block: queues host requests and
// swaps spi command fields only on spi done boundaries, parking in between.
module spi_cmd_sequencer
  import spi_cmd_sequencer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PARK_ADDR  = PARK_ADDR_DEF,
  parameter int         TIMEOUT    = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  spi_cmd_sequencer_if.slave   bus_if,
  output logic                 timeout_o
);

  localparam int       WD_W     = $clog2(TIMEOUT + 1);
  localparam spi_cmd_t PARK_CMD = '{wr: 1'b0, addr: PARK_ADDR, wdata: 8'h00};

  spi_seq_state_t state_q, state_d;
  spi_cmd_t       cmd_q, cmd_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  spi_cmd_t fifo_head;
  spi_cmd_t fifo_push_data;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     launch_ok;

  assign launch_ok      = !fifo_empty && (!rsp_valid_q || bus_if.rsp_ready);
  assign bus_if.req_ready = !fifo_full || fifo_pop;
  assign fifo_push      = bus_if.req_valid && bus_if.req_ready;
  assign fifo_push_data = '{wr: bus_if.req_wr, addr: bus_if.req_addr, wdata: bus_if.req_wdata};

  spi_cmd_sequencer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Command fields only move on the edge that samples spi_done, so spi sees
  // them stable through its load and operation phases.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    fifo_pop    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_q && bus_if.rsp_ready) rsp_valid_d = 1'b0;
    case (state_q)
      PARK: begin
        if (bus_if.spi_done) begin
          if (launch_ok) begin
            fifo_pop = 1'b1;
            cmd_d    = fifo_head;
            state_d  = BUSY;
          end else begin
            cmd_d = PARK_CMD;
          end
        end
      end
      BUSY: begin
        if (bus_if.spi_done) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cmd_q.wr ? 8'h00 : bus_if.spi_dout;
          rsp_err_d   = bus_if.spi_err;
          cmd_d       = PARK_CMD;
          state_d     = PARK;
        end
      end
      default: begin
        cmd_d   = PARK_CMD;
        state_d = PARK;
      end
    endcase
  end

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (bus_if.spi_done) begin
      wd_d = '0;
    end else if (wd_q != WD_W'(TIMEOUT)) begin
      wd_d = wd_q + 1'b1;
    end
    if (wd_d == WD_W'(TIMEOUT)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PARK;
      cmd_q       <= PARK_CMD;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wd_q        <= wd_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus_if.spi_wr    = cmd_q.wr;
  assign bus_if.spi_addr  = cmd_q.addr;
  assign bus_if.spi_din   = cmd_q.wdata;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_rdata = rsp_rdata_q;
  assign bus_if.rsp_err   = rsp_err_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: behavioural spi model, request-order scoreboard,
// directed vector table and multi-cycle corner sequences.
module tb_spi_cmd_sequencer;
  import spi_cmd_sequencer_pkg::*;

  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout;

  spi_cmd_sequencer_if bus();

  spi_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .PARK_ADDR  (8'hFF),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus_if    (bus),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- spi behavioural model ----------------
  logic       spi_run = 1'b0;
  logic [7:0] spi_mem [SPI_MEM_DEPTH];

  initial begin
    int       cnt;
    logic     cap;
    spi_cmd_t cur;
    for (int i = 0; i < SPI_MEM_DEPTH; i++) spi_mem[i] = 8'(i) ^ 8'h5A;
    bus.spi_done = 1'b0;
    bus.spi_dout = 8'h00;
    bus.spi_err  = 1'b0;
    cnt = 3;
    cap = 1'b1;
    cur = '{1'b0, 8'hFF, 8'h00};
    forever begin
      @(negedge clk);
      bus.spi_done = 1'b0;
      if (!rst_n) begin
        cnt = 3;
        cap = 1'b1;
      end else begin
        if (cap) begin
          cur = '{bus.spi_wr, bus.spi_addr, bus.spi_din};
          cap = 1'b0;
        end
        if (spi_run) begin
          if (cnt == 0) begin
            if (cur.addr >= 8'(SPI_MEM_DEPTH)) begin
              bus.spi_err  = 1'b1;
              bus.spi_dout = 8'h00;
            end else if (cur.wr) begin
              spi_mem[cur.addr[4:0]] = cur.wdata;
              bus.spi_err  = 1'b0;
              bus.spi_dout = 8'h00;
            end else begin
              bus.spi_err  = 1'b0;
              bus.spi_dout = spi_mem[cur.addr[4:0]];
            end
            bus.spi_done = 1'b1;
            cnt = $urandom_range(2, 5);
            cap = 1'b1;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- pre-edge sampler ----------------
  logic       pre_rst = 1'b1;
  logic       pre_req_fire = 1'b0;
  logic       pre_rsp_fire = 1'b0;
  logic       pre_done = 1'b0;
  spi_cmd_t   pre_req;
  spi_cmd_t   pre_fields;
  logic [7:0] pre_rdata;
  logic       pre_err;

  always begin
    @(negedge clk);
    #3;
    pre_rst      = !rst_n;
    pre_req_fire = rst_n && bus.req_valid && bus.req_ready;
    pre_rsp_fire = rst_n && bus.rsp_valid && bus.rsp_ready;
    pre_done     = bus.spi_done;
    pre_req      = '{bus.req_wr, bus.req_addr, bus.req_wdata};
    pre_fields   = '{bus.spi_wr, bus.spi_addr, bus.spi_din};
    pre_rdata    = bus.rsp_rdata;
    pre_err      = bus.rsp_err;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] ref_mem [SPI_MEM_DEPTH];
  int         rsp_cnt = 0;
  logic [7:0] last_rdata = 8'h00;
  logic       last_err = 1'b0;

  initial for (int i = 0; i < SPI_MEM_DEPTH; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

  always @(posedge clk) begin
    rsp_t     e;
    spi_cmd_t now_fields;
    #1;
    now_fields = '{bus.spi_wr, bus.spi_addr, bus.spi_din};
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (pre_req_fire) begin
        if (pre_req.addr >= 8'(SPI_MEM_DEPTH)) begin
          e = '{8'h00, 1'b1};
        end else if (pre_req.wr) begin
          ref_mem[pre_req.addr[4:0]] = pre_req.wdata;
          e = '{8'h00, 1'b0};
        end else begin
          e = '{ref_mem[pre_req.addr[4:0]], 1'b0};
        end
        exp_q.push_back(e);
      end
      if (pre_rsp_fire) begin
        rsp_cnt++;
        last_rdata = pre_rdata;
        last_err   = pre_err;
        $display("rsp %0d: rdata=%02h err=%0d", rsp_cnt, pre_rdata, pre_err);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rdata=%02h err=%0d required no response", pre_rdata, pre_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", pre_rdata, e.rdata);
          check("rsp_err", pre_err, e.err);
        end
      end
      if (!pre_rst && now_fields != pre_fields) begin
        n_cmp++;
        if (!pre_done) begin
          n_bad++;
          $display("FAIL spi_field_stability: got %05h without spi_done required %05h",
                   now_fields, pre_fields);
        end
      end
    end
  end

  // ---------------- random response backpressure ----------------
  logic rnd_mode = 1'b0;
  always @(negedge clk) if (rnd_mode) bus.rsp_ready = ($urandom_range(0, 3) != 0);

  // ---------------- helper tasks ----------------
  task automatic send_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    bit ok = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk);
      #1;
      if (pre_req_fire) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_accept: got no accept for addr %02h required accept within 400 cycles", addr);
    end
  endtask

  task automatic req_idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int target, input string name);
    bit ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      #2;
      if (rsp_cnt >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d responses required %0d", name, rsp_cnt, target);
    end
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got rsp_valid=0 required 1 within 200 cycles", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish required finish before time limit");
    $fatal(1, "time limit");
  end

  // ---------------- main test ----------------
  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int  base;
    bit  ok;
    logic [7:0] a;
    vecs[0] = '{1'b1, 8'd5,  8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'd5,  8'h00, 8'hA5, 1'b0};
    vecs[2] = '{1'b1, 8'd40, 8'h77, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'd8,  8'h00, 8'h52, 1'b0};
    vecs[4] = '{1'b0, 8'd5,  8'h00, 8'hA5, 1'b0};
    vecs[5] = '{1'b1, 8'd31, 8'h3C, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'd31, 8'h00, 8'h3C, 1'b0};
    vecs[7] = '{1'b0, 8'd32, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 8'd6,  8'h00, 8'h5C, 1'b0};
    vecs[9] = '{1'b1, 8'd0,  8'h11, 8'h00, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_spi_wr", bus.spi_wr, 0);
    check("rst_spi_addr", bus.spi_addr, 8'hFF);
    check("rst_spi_din", bus.spi_din, 0);
    check("rst_timeout", timeout, 0);
    check("rst_req_ready", bus.req_ready, 1);

    // Watchdog boundary with spi silent
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("timeout_one_before", timeout, 0);
    @(posedge clk);
    #1;
    check("timeout_at_limit", timeout, 1);
    spi_run = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("timeout_sticky", timeout, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("timeout_reset_clear", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      base = rsp_cnt;
      send_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      req_idle();
      wait_rsps(base + 1, $sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_rdata", i), last_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), last_err, vecs[i].exp_err);
    end

    // Backpressure: one response held, two commands left queued
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    base = rsp_cnt;
    send_req(1'b1, 8'd1, 8'h11);
    send_req(1'b1, 8'd2, 8'h22);
    send_req(1'b1, 8'd3, 8'h33);
    req_idle();
    wait_valid("bp_valid_wait");
    repeat (40) @(posedge clk);
    #1;
    check("bp_rsp_valid_held", bus.rsp_valid, 1);
    check("bp_rsp_rdata_held", bus.rsp_rdata, 0);
    check("bp_rsp_err_held", bus.rsp_err, 0);
    check("bp_fifo_count", 32'(dut.u_fifo.count_q), 2);
    check("bp_no_rsp_taken", rsp_cnt, base);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    wait_rsps(base + 3, "bp_release");
    for (int i = 1; i <= 3; i++) begin
      base = rsp_cnt;
      send_req(1'b0, 8'(i), 8'h00);
      req_idle();
      wait_rsps(base + 1, "bp_readback_wait");
      check($sformatf("bp_readback%0d", i), last_rdata, 8'(i * 8'h11));
    end

    // FIFO full with spi paused, then push/pop on the same edge
    @(posedge clk);
    #1;
    spi_run = 1'b0;
    base = rsp_cnt;
    for (int i = 1; i <= 4; i++) send_req(1'b0, 8'(i), 8'h00);
    @(negedge clk);
    bus.req_addr = 8'd5;
    #4;
    check("full_req_ready", bus.req_ready, 0);
    check("full_fifo_count", 32'(dut.u_fifo.count_q), 4);
    spi_run = 1'b1;
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      if (pre_req_fire) begin
        ok = 1;
        break;
      end
    end
    check("full_push_accepted", ok, 1);
    check("full_push_with_done", pre_done, 1);
    check("full_push_pop_count", 32'(dut.u_fifo.count_q), 4);
    req_idle();
    wait_rsps(base + 5, "full_drain");

    // Randomized traffic with random response backpressure
    base = rsp_cnt;
    @(posedge clk);
    #1;
    rnd_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      send_req(1'($urandom_range(0, 1)), a, 8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        req_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    req_idle();
    @(posedge clk);
    #1;
    rnd_mode = 1'b0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    wait_rsps(base + 24, "random_drain");
    check("random_queue_empty", exp_q.size(), 0);
    check("random_no_timeout", timeout, 0);

    // Reset while a write is in flight
    base = rsp_cnt;
    send_req(1'b1, 8'd7, 8'h99);
    send_req(1'b1, 8'd8, 8'h98);
    req_idle();
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      #1;
      if (bus.spi_addr == 8'd7) begin
        ok = 1;
        break;
      end
    end
    check("midbusy_reached", ok, 1);
    check("midbusy_fifo_count", 32'(dut.u_fifo.count_q), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_spi_addr", bus.spi_addr, 8'hFF);
    check("midrst_spi_wr", bus.spi_wr, 0);
    check("midrst_fifo_count", 32'(dut.u_fifo.count_q), 0);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    check("midrst_rsp_lost", rsp_cnt, base);

    // Sanity after reset
    base = rsp_cnt;
    send_req(1'b1, 8'd12, 8'hC3);
    send_req(1'b0, 8'd12, 8'h00);
    req_idle();
    wait_rsps(base + 2, "post_reset_wait");
    check("post_reset_read", last_rdata, 8'hC3);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
